// File: rtl/rr_mux_pkg.sv
// Shared types and the circular first-one picker for the round-robin read-data arbiter.
// The picker works on a fixed MAX_CNT-wide vector; callers zero-extend and slice.
package rr_mux_pkg;

  localparam int unsigned MAX_CNT   = 32;
  localparam int unsigned MAX_IDX_W = 5;

  typedef enum logic {EMPTY, FULL} slot_state_e;

  typedef logic [MAX_CNT-1:0] rr_vec_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
    rr_vec_t              onehot;
  } rr_pick_t;

  function automatic int unsigned idx_width(input int unsigned cnt);
    return (cnt > 1) ? $clog2(cnt) : 1;
  endfunction

  // First set bit scanning circularly from ptr+1, wrapping at cnt (ptr < cnt).
  function automatic rr_pick_t rr_pick(input rr_vec_t vld, input int unsigned ptr,
                                       input int unsigned cnt);
    rr_pick_t    p;
    int unsigned i;
    p = '0;
    for (int unsigned k = 1; k <= MAX_CNT; k++) begin
      if (k <= cnt) begin
        i = ptr + k;
        if (i >= cnt) i = i - cnt;
        if (!p.found && vld[i]) begin
          p.found     = 1'b1;
          p.idx       = i[MAX_IDX_W-1:0];
          p.onehot[i] = 1'b1;
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester-side and downstream handshake bundle of the round-robin read-data arbiter.
interface rr_mux_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT   = 5
) ();

  logic [CNT-1:0]       req_vld;
  logic [WIDTH*CNT-1:0] req_data;
  logic [CNT-1:0]       req_ack;
  logic                 out_vld;
  logic [WIDTH-1:0]     out_data;
  logic [CNT-1:0]       out_src;
  logic                 out_rdy;

  modport master (
    output req_vld, req_data, out_rdy,
    input  req_ack, out_vld, out_data, out_src
  );

  modport slave (
    input  req_vld, req_data, out_rdy,
    output req_ack, out_vld, out_data, out_src
  );

endinterface

// File: rtl/onehot_mux.sv
// AND-OR multiplexer driven by a one-hot (or zero) select; zero select yields zero.
module onehot_mux #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned CNT          = 5,
  parameter bit          CHECK_ONEHOT = 1'b1
) (
  input  logic [CNT-1:0]       sel,
  input  logic [WIDTH*CNT-1:0] data,
  output logic [WIDTH-1:0]     out
);

  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < CNT; i++) begin
      out = out | (data[WIDTH*i +: WIDTH] & {WIDTH{sel[i]}});
    end
  end

  if (CHECK_ONEHOT) begin : g_chk
    always_comb begin
      assert ($onehot0(sel));
    end
  end

endmodule

// File: rtl/rr_arb_core.sv
// Combinational round-robin grant: one-hot grant and its index, gated by can_load.
module rr_arb_core
  import rr_mux_pkg::*;
#(
  parameter int unsigned CNT   = 5,
  parameter int unsigned IDX_W = 3
) (
  input  logic [CNT-1:0]   req_vld,
  input  logic [IDX_W-1:0] last_gnt,
  input  logic             can_load,
  output logic [CNT-1:0]   gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  rr_vec_t  vld_ext;
  rr_pick_t pick;
  logic     pick_unused;

  always_comb begin
    vld_ext              = '0;
    vld_ext[CNT-1:0]     = req_vld;
    pick                 = rr_pick(vld_ext, 32'(last_gnt), CNT);
    gnt                  = '0;
    gnt_idx              = pick.idx[IDX_W-1:0];
    if (can_load && pick.found) gnt = pick.onehot[CNT-1:0];
  end

  assign pick_unused = ^pick;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter over CNT requesters feeding a single registered output slot.
// Supports CNT up to rr_mux_pkg::MAX_CNT.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT   = 5
) (
  input logic             clk,
  input logic             rst_n,
  rr_mux_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = idx_width(CNT);

  slot_state_e      state_q;
  logic [IDX_W-1:0] last_gnt_q;
  logic [IDX_W-1:0] gnt_idx;
  logic [CNT-1:0]   gnt;
  logic [CNT-1:0]   out_src_q;
  logic [WIDTH-1:0] mux_data;
  logic [WIDTH-1:0] out_data_q;
  logic             can_load;

  // rst_n gating keeps req_ack low during reset even with requests present.
  assign can_load = rst_n && ((state_q == EMPTY) || bus.out_rdy);

  rr_arb_core #(
    .CNT   (CNT),
    .IDX_W (IDX_W)
  ) u_core (
    .req_vld  (bus.req_vld),
    .last_gnt (last_gnt_q),
    .can_load (can_load),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx)
  );

  onehot_mux #(
    .WIDTH        (WIDTH),
    .CNT          (CNT),
    .CHECK_ONEHOT (1'b0)
  ) u_mux (
    .sel  (gnt),
    .data (bus.req_data),
    .out  (mux_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_src_q  <= '0;
      last_gnt_q <= IDX_W'(CNT - 1);
    end else if (|gnt) begin
      state_q    <= FULL;
      out_data_q <= mux_data;
      out_src_q  <= gnt;
      last_gnt_q <= gnt_idx;
    end else if (bus.out_rdy) begin
      state_q    <= EMPTY;
    end
  end

  assign bus.req_ack  = gnt;
  assign bus.out_vld  = (state_q == FULL);
  assign bus.out_data = out_data_q;
  assign bus.out_src  = out_src_q;

`ifndef SYNTHESIS
  a_ack_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.req_ack));
  a_src_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    bus.out_vld |-> $onehot(bus.out_src));
  a_ack_has_vld: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.req_ack & ~bus.req_vld) == '0);
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed table and sequences plus random traffic vs a reference model.
module tb_rr_mux_arbiter;

  localparam int W = 32;
  localparam int N = 5;

  logic clk;
  logic rst_n;

  rr_mux_arbiter_if #(.WIDTH(W), .CNT(N)) bus ();

  rr_mux_arbiter #(.WIDTH(W), .CNT(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total;
  int n_pass;

  // Reference model: slot contents, pointer as plain integer, requester data array.
  logic          m_vld;
  logic [W-1:0]  m_data;
  logic [N-1:0]  m_src;
  int            m_last;
  int            m_gnt;
  logic [N-1:0]  m_ack;
  logic [W-1:0]  dval [N];

  typedef struct {
    logic [N-1:0] vld;
    logic         rdy;
    logic [N-1:0] ack;
    logic         ovld;
    logic [W-1:0] odata;
    logic [N-1:0] osrc;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic set_data(input int i, input logic [W-1:0] d);
    dval[i] = d;
    bus.req_data[W*i +: W] = d;
  endtask

  task automatic model_reset();
    m_vld  = 1'b0;
    m_data = '0;
    m_src  = '0;
    m_last = N - 1;
    m_gnt  = -1;
    m_ack  = '0;
  endtask

  function automatic int pick(input logic [N-1:0] vld, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (vld[i]) return i;
    end
    return -1;
  endfunction

  task automatic check_outs(input string tag);
    check({tag, "_vld"},  {31'b0, bus.out_vld}, {31'b0, m_vld});
    check({tag, "_data"}, bus.out_data, m_data);
    check({tag, "_src"},  {27'b0, bus.out_src}, {27'b0, m_src});
  endtask

  // Drive inputs (at posedge+1), then at negedge compare against the model.
  task automatic apply(input logic [N-1:0] vld, input logic rdy);
    bus.req_vld = vld;
    bus.out_rdy = rdy;
    @(negedge clk);
    m_gnt = (!m_vld || rdy) ? pick(vld, m_last) : -1;
    m_ack = (m_gnt >= 0) ? N'(1 << m_gnt) : '0;
    check("m_ack", {27'b0, bus.req_ack}, {27'b0, m_ack});
    check_outs("m");
  endtask

  task automatic advance();
    @(posedge clk);
    if (m_gnt >= 0) begin
      m_vld  = 1'b1;
      m_data = dval[m_gnt];
      m_src  = N'(1 << m_gnt);
      m_last = m_gnt;
    end else if (bus.out_rdy) begin
      m_vld = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.req_vld = '0;
    bus.out_rdy = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_ack", {27'b0, bus.req_ack}, '0);
      check_outs("rst");
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] cur;
    logic         rdy;

    n_total     = 0;
    n_pass      = 0;
    bus.req_data = '0;
    for (int i = 0; i < N; i++) dval[i] = '0;

    // Reset then idle.
    do_reset();
    for (int c = 0; c < 2; c++) begin
      apply('0, 1'b0);
      check("idle_ack", {27'b0, bus.req_ack}, '0);
      check("idle_vld", {31'b0, bus.out_vld}, '0);
      advance();
    end

    // Single request.
    set_data(2, 32'hDEAD_BEEF);
    apply(5'b00100, 1'b1);
    check("single_ack", {27'b0, bus.req_ack}, 32'h4);
    check("single_vld0", {31'b0, bus.out_vld}, '0);
    advance();
    apply('0, 1'b1);
    check("single_vld1", {31'b0, bus.out_vld}, 32'h1);
    check("single_data", bus.out_data, 32'hDEAD_BEEF);
    check("single_src", {27'b0, bus.out_src}, 32'h4);
    advance();
    apply('0, 1'b1);
    check("single_drain", {31'b0, bus.out_vld}, '0);
    check("single_hold", bus.out_data, 32'hDEAD_BEEF);
    advance();

    // Round-robin rotation table, data_i = i.
    do_reset();
    for (int i = 0; i < N; i++) set_data(i, W'(i));
    for (int r = 0; r < 10; r++) begin
      tbl[r].vld   = 5'b11111;
      tbl[r].rdy   = 1'b1;
      tbl[r].ack   = N'(1 << (r % N));
      tbl[r].ovld  = (r != 0);
      tbl[r].odata = (r == 0) ? '0 : W'((r - 1) % N);
      tbl[r].osrc  = (r == 0) ? '0 : N'(1 << ((r - 1) % N));
    end
    foreach (tbl[r]) begin
      apply(tbl[r].vld, tbl[r].rdy);
      check("rot_ack",  {27'b0, bus.req_ack}, {27'b0, tbl[r].ack});
      check("rot_vld",  {31'b0, bus.out_vld}, {31'b0, tbl[r].ovld});
      check("rot_data", bus.out_data, tbl[r].odata);
      check("rot_src",  {27'b0, bus.out_src}, {27'b0, tbl[r].osrc});
      advance();
    end

    // Backpressure: slot holds data 7 from requester 0.
    do_reset();
    set_data(0, 32'd7);
    apply(5'b00001, 1'b1);
    check("bp_first_ack", {27'b0, bus.req_ack}, 32'h1);
    advance();
    for (int c = 0; c < 4; c++) begin
      apply(5'b11111, 1'b0);
      check("bp_ack",  {27'b0, bus.req_ack}, '0);
      check("bp_data", bus.out_data, 32'd7);
      check("bp_vld",  {31'b0, bus.out_vld}, 32'h1);
      advance();
    end
    apply(5'b11111, 1'b1);
    check("bp_release_ack", {27'b0, bus.req_ack}, 32'h2);
    advance();
    apply(5'b11111, 1'b1);
    check("bp_next_data", bus.out_data, 32'd1);
    check("bp_next_ack", {27'b0, bus.req_ack}, 32'h4);
    advance();
    apply('0, 1'b1);
    advance();

    // Pointer wrap and skip of an absent requester.
    do_reset();
    apply(5'b01000, 1'b1);
    check("wrap_ack3", {27'b0, bus.req_ack}, 32'h8);
    advance();
    apply(5'b00101, 1'b1);
    check("wrap_ack0", {27'b0, bus.req_ack}, 32'h1);
    advance();
    apply(5'b00100, 1'b1);
    check("wrap_ack2", {27'b0, bus.req_ack}, 32'h4);
    advance();
    apply('0, 1'b1);
    check("wrap_src", {27'b0, bus.out_src}, 32'h4);
    advance();

    // Asynchronous reset while the slot is full.
    apply(5'b00010, 1'b1);
    advance();
    apply('0, 1'b0);
    check("mid_full", {31'b0, bus.out_vld}, 32'h1);
    #2;
    rst_n       = 1'b0;
    bus.req_vld = 5'b11111;
    model_reset();
    #1;
    check("mid_rst_vld", {31'b0, bus.out_vld}, '0);
    check("mid_rst_ack", {27'b0, bus.req_ack}, '0);
    check_outs("mid_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(5'b11111, 1'b1);
    check("mid_first_ack", {27'b0, bus.req_ack}, 32'h1);
    advance();

    // Random traffic with legal drops and backpressure.
    do_reset();
    cur = '0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (cur[i] && !m_ack[i]) begin
          if ($urandom_range(0, 7) == 0) cur[i] = 1'b0;
        end else begin
          cur[i] = ($urandom_range(0, 1) == 1);
          if (cur[i]) set_data(i, W'($urandom));
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      m_ack = '0;
      apply(cur, rdy);
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and registered output stage for a shared one-hot read-data mux.
- Shares one WIDTH-bit return path between CNT requesters, for example the register-slice read responses returned to the bus bridge.
- Picks one valid requester per cycle, acks it, and registers its data into a single-entry output slot with a valid/ready handshake downstream.
- Guarantees that the mux select is always one-hot or zero.

Parameters:
- WIDTH, 32, data width per requester.
- CNT, 5, number of requesters; must be at least 1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- req_vld  input  CNT  per-requester valid; held high until acked.
- req_data  input  WIDTH*CNT  requester i data in bits [WIDTH*i +: WIDTH]; stable while req_vld[i] is high.
- req_ack  output  CNT  one-hot, combinational; high in the cycle requester i is accepted.
- out_vld  output  1  registered; output slot full.
- out_data  output  WIDTH  registered data from the granted requester.
- out_src  output  CNT  registered one-hot index of the requester that supplied out_data.
- out_rdy  input  1  downstream ready; a transfer occurs when out_vld and out_rdy are both high.

Behaviour:
- Reset values:
  - out_vld=0, out_data=0, out_src=0.
  - req_ack=0, because the slot logic forces it to 0 while rst_n is low.
  - Priority pointer last_gnt = CNT-1, so requester 0 has the highest priority after reset.
- Slot states:
  - EMPTY: out_vld=0.
  - FULL: out_vld=1.
  - can_load = EMPTY, or (FULL and out_rdy).
- Grant rule:
  - When can_load is true and |req_vld, grant the first set req_vld bit scanning circularly from last_gnt+1 mod CNT.
  - Drive req_ack[g]=1 in the same cycle.
  - When can_load is false, req_ack=0 regardless of req_vld.
- On a grant, at the next clk edge:
  - out_data <= req_data[g].
  - out_src <= one-hot(g).
  - out_vld <= 1.
  - last_gnt <= g.
- Transitions:
  - EMPTY to FULL on a grant.
  - FULL to EMPTY when out_rdy is high and there is no grant.
  - FULL stays FULL on out_rdy with a simultaneous grant (back-to-back, one transfer per cycle).
  - FULL stays FULL while out_rdy is low.
- Latency:
  - req_vld to req_ack is 0 cycles.
  - req_ack to out_vld is 1 cycle.
  - Sustained throughput is 1 word/cycle while out_rdy=1.
- Backpressure: while FULL and out_rdy=0, out_data, out_src and out_vld hold stable, and last_gnt is unchanged.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,CNT-1,0,...; no requester waits more than CNT grants.
- Requester drops req_vld before ack: legal. It is simply not granted, and no state changes.
- With no request and can_load true: req_ack=0, last_gnt is unchanged, and out_data is not updated; it keeps its old value while out_vld=0.
- CNT=1: the requester is always granted when can_load is true; the pointer is trivially 0.
- Reset asserted mid-operation:
  - Immediate clear to reset values; any in-flight word in the slot is dropped.
  - Requesters must re-present after reset.
- Datapath: the mux select is the combinational one-hot grant vector, feeding an AND-OR one-hot mux, so no priority encoding is applied to the data.
- Assertions (simulation only):
  - req_ack is $onehot0.
  - out_src is $onehot when out_vld=1.
  - req_ack[i] implies req_vld[i].

Decomposition:
- Package rr_mux_pkg: function rr_pick (circular first-one from pointer, returns index and one-hot), and localparam IDX_W = $clog2(CNT) (minimum 1).
- Sub-module rr_arb_core: purely combinational grant from req_vld, last_gnt and can_load; produces the one-hot grant and index.
- Data selection reuses the codebase's existing one-hot AND-OR mux cell, with its one-hot check disabled.
- The slot register and pointer live in rr_mux_arbiter.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, then all inputs 0 → out_vld=0, out_data=0, out_src=0, req_ack=0 every cycle.
- Single request: req_vld=5'b00100, data2=32'hDEAD_BEEF, out_rdy=1 → req_ack=5'b00100 in cycle 0; next cycle out_vld=1, out_data=32'hDEAD_BEEF, out_src=5'b00100.
- Round-robin rotation: all five req_vld held high with data_i=i, out_rdy=1 for 10 cycles → ack sequence 0,1,2,3,4,0,1,2,3,4; out_data lags by 1 cycle with the same values.
- Backpressure: slot FULL with data 7, out_rdy=0 for 4 cycles while req_vld=5'b11111 → req_ack=0 and out_data=7 stable. When out_rdy rises, the next ack goes to (last_gnt+1) in that same cycle, back-to-back.
- Pointer wrap and skip: last_gnt=3, req_vld=5'b00101 → grant 0, then grant 2; requester 4's absence is skipped.
- Mid-transfer reset: FULL with out_vld=1, assert rst_n low asynchronously between edges → out_vld=0 immediately. After release, req_vld=5'b11111 grants requester 0 first.
